ram_2r1w_bist: RTL and testbench

RAM_2R1W_BIST -- requirements
Module: ram_2r1w_bist

---
 rtl/ram_bist_pkg.sv | 42 ++++
 rtl/ram_bist_cmp.sv | 60 ++++++
 rtl/ram_2r1w_bist.sv | 177 +++++++++++++++++
 tb/tb_ram_2r1w_bist.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared FSM state, March C- element encoding and default sizes
package ram_bist_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEMD       = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    // down: address walks MEMD-1..0; rw: read then write per address;
    // rd_only: single dual-port read; rd_one/wr_one: pattern is all-ones
    typedef struct packed {
        logic down;
        logic rw;
        logic rd_only;
        logic rd_one;
        logic wr_one;
    } elem_t;

    function automatic elem_t elem_info(input logic [2:0] e);
        elem_t t;
        t.down    = (e == E3) || (e == E4);
        t.rw      = (e >= E1) && (e <= E4);
        t.rd_only = (e == E5);
        t.rd_one  = (e == E2) || (e == E4);
        t.wr_one  = (e == E1) || (e == E3);
        return t;
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// ram_bist_cmp: expected-value delay line and read-data comparator
module ram_bist_cmp #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_vld,
    input  logic                  in_dual,
    input  logic [DATA_WIDTH-1:0] in_exp,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [2:0]            in_elem,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic                  mis,
    output logic                  mis_port,
    output logic [ADDR_WIDTH-1:0] mis_addr,
    output logic [2:0]            mis_elem
);

    typedef struct packed {
        logic                  vld;
        logic                  dual;
        logic [DATA_WIDTH-1:0] expv;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            elem;
    } ent_t;

    ent_t [RD_LAT-1:0] pipe_q, pipe_d;
    ent_t last;
    logic mis0, mis1;

    // shift one entry per cycle; a mismatch drops everything still in flight
    always_comb begin
        pipe_d[0].vld  = in_vld;
        pipe_d[0].dual = in_dual;
        pipe_d[0].expv = in_exp;
        pipe_d[0].addr = in_addr;
        pipe_d[0].elem = in_elem;
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
        if (flush) for (int i = 0; i < RD_LAT; i++) pipe_d[i].vld = 1'b0;
    end

    // delay line registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign last     = pipe_q[RD_LAT-1];
    assign mis0     = last.vld && (dout != last.expv);
    assign mis1     = last.vld && last.dual && (dout1 != last.expv);
    assign mis      = mis0 || mis1;
    assign mis_port = !mis0;
    assign mis_addr = last.addr;
    assign mis_elem = last.elem;

endmodule

// File: rtl/ram_2r1w_bist.sv
// ram_2r1w_bist: March C- BIST controller for a 1RW + 1R SRAM macro
module ram_2r1w_bist
    import ram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WMASKS = DATA_WIDTH / 8,
    parameter int MEMD       = DEF_MEMD,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic                  fail_port,
    output logic                  csb,
    output logic                  web,
    output logic [NUM_WMASKS-1:0] wmask,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEMD - 1);

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;
    logic [CW-1:0]         dcnt_q, dcnt_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic                  fail_port_q, fail_port_d;

    elem_t                 info, info_nx;
    logic                  issue, is_read, is_wr, last_addr, step_done;
    logic                  mis, mis_port;
    logic [ADDR_WIDTH-1:0] mis_addr;
    logic [2:0]            mis_elem;

    assign info      = elem_info(elem_q);
    assign info_nx   = elem_info(elem_q + 3'd1);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign issue     = (state_q == ST_RUN) && !mis;
    assign is_read   = info.rd_only || (info.rw && !phase_q);
    assign is_wr     = issue && !is_read;
    assign step_done = !info.rw || phase_q;
    assign last_addr = info.down ? (addr_q == '0) : (addr_q == LAST);

    assign csb       = !issue;
    assign web       = !is_wr;
    assign wmask     = {NUM_WMASKS{is_wr}};
    assign addr      = issue ? addr_q : '0;
    assign din       = {DATA_WIDTH{is_wr && info.wr_one}};
    assign csb1      = !(issue && info.rd_only);
    assign addr1     = (issue && info.rd_only) ? addr_q : '0;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;
    assign fail_port = fail_port_q;

    ram_bist_cmp #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .RD_LAT    (RD_LAT)
    ) u_cmp (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (mis),
        .in_vld  (issue && is_read),
        .in_dual (info.rd_only),
        .in_exp  ({DATA_WIDTH{info.rd_one}}),
        .in_addr (addr_q),
        .in_elem (elem_q),
        .dout    (dout),
        .dout1   (dout1),
        .mis     (mis),
        .mis_port(mis_port),
        .mis_addr(mis_addr),
        .mis_elem(mis_elem)
    );

    // sequencer: one op per cycle, elements chained back to back, first mismatch ends the run
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        dcnt_d      = dcnt_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_port_d = fail_port_q;
        if (busy && mis) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            pass_d      = 1'b0;
            fail_addr_d = mis_addr;
            fail_elem_d = mis_elem;
            fail_port_d = mis_port;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) begin
                    state_d     = ST_RUN;
                    elem_d      = E0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    dcnt_d      = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_port_d = 1'b0;
                end
                ST_RUN: begin
                    phase_d = !step_done;
                    if (step_done && !last_addr)
                        addr_d = info.down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
                    else if (step_done && elem_q == E5)
                        state_d = ST_DRAIN;
                    else if (step_done) begin
                        elem_d = elem_q + 3'd1;
                        addr_d = info_nx.down ? LAST : '0;
                    end
                end
                ST_DRAIN: if (dcnt_q == CW'(RD_LAT - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CW'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            elem_q      <= E0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            dcnt_q      <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_port_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            dcnt_q      <= dcnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_port_q <= fail_port_d;
        end
    end

endmodule

// File: tb/tb_ram_2r1w_bist.sv
// tb_ram_2r1w_bist: directed bench for the March C- BIST with behavioural SRAM models
module tb_ram_2r1w_bist;

    logic        clk = 1'b0;
    logic        rst_n, start, start2, stuck, p1f;
    int          cmps = 0;
    int          errs = 0;
    int          bad_csb = 0;
    int          n;

    logic        busy, done, pass, fail_port, csb, web, csb1;
    logic [7:0]  fail_addr, addr, addr1;
    logic [2:0]  fail_elem;
    logic [3:0]  wmask;
    logic [31:0] din, dout, dout1;

    logic        busy2, done2, pass2, fail_port2, csb_2, web_2, csb1_2;
    logic [7:0]  fail_addr2, addr_2, addr1_2;
    logic [2:0]  fail_elem2;
    logic [3:0]  wmask_2;
    logic [31:0] din_2, dout_2, dout1_2;

    logic [31:0] mem  [256];
    logic [31:0] mem2 [256];
    logic [31:0] r0, r1, r0a, r0b, r1a, r1b;

    always #5 clk = ~clk;

    ram_2r1w_bist #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_port(fail_port),
        .csb(csb), .web(web), .wmask(wmask), .addr(addr), .din(din), .dout(dout),
        .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    ram_2r1w_bist #(.RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_addr(fail_addr2), .fail_elem(fail_elem2), .fail_port(fail_port2),
        .csb(csb_2), .web(web_2), .wmask(wmask_2), .addr(addr_2), .din(din_2), .dout(dout_2),
        .csb1(csb1_2), .addr1(addr1_2), .dout1(dout1_2)
    );

    // 1-cycle SRAM with optional stuck-at-1 on word 0x5A bit 7 and forced port1 word 0xFF
    always @(posedge clk) begin
        if (!csb && !web)
            for (int b = 0; b < 4; b++) if (wmask[b]) mem[addr][b*8 +: 8] <= din[b*8 +: 8];
        if (!csb && web) r0 <= mem[addr] | ((stuck && addr == 8'h5A) ? 32'h80 : 32'h0);
        if (!csb1) r1 <= (p1f && addr1 == 8'hFF) ? 32'hFFFF_FFFF : mem[addr1];
    end
    assign dout  = r0;
    assign dout1 = r1;

    // 2-cycle SRAM for the RD_LAT=2 instance
    always @(posedge clk) begin
        if (!csb_2 && !web_2)
            for (int b = 0; b < 4; b++) if (wmask_2[b]) mem2[addr_2][b*8 +: 8] <= din_2[b*8 +: 8];
        if (!csb_2 && web_2) r0a <= mem2[addr_2];
        if (!csb1_2) r1a <= mem2[addr1_2];
        r0b <= r0a;
        r1b <= r1a;
    end
    assign dout_2  = r0b;
    assign dout1_2 = r1b;

    always @(negedge clk) if (rst_n && done && (!csb || !csb1)) bad_csb++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input bit two);
        @(negedge clk);
        if (two) start2 = 1'b1;
        else     start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic run(input bit two, input int rs, input int stop_at, output int cnt);
        cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            if ((two ? done2 : done) || cnt == stop_at) break;
            if (two ? busy2 : busy) cnt++;
            start = !two && (i == rs);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; stuck = 1'b0; p1f = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_fail_elem", fail_elem, 0);
        chk("rst_fail_port", fail_port, 0);
        chk("rst_csb", csb, 1);
        chk("rst_web", web, 1);
        chk("rst_csb1", csb1, 1);
        chk("rst_wmask", wmask, 0);
        chk("rst_addr", addr, 0);
        chk("rst_addr1", addr1, 0);
        chk("rst_din", din, 0);
        chk("rst_busy2", busy2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        // fault-free run, first op is E0 write of zeros at address 0
        go(0);
        chk("a_first_csb", csb, 0);
        chk("a_first_web", web, 0);
        chk("a_first_wmask", wmask, 4'hF);
        chk("a_first_addr", addr, 0);
        chk("a_first_din", din, 0);
        chk("a_first_csb1", csb1, 1);
        run(0, -1, -1, n);
        chk("a_busy_cycles", n, 2561);
        chk("a_done", done, 1);
        chk("a_pass", pass, 1);
        chk("a_idle_csb", csb, 1);
        chk("a_idle_wmask", wmask, 0);
        // start from DONE, plus an ignored start mid-run
        go(0);
        chk("b_done_cleared", done, 0);
        chk("b_pass_cleared", pass, 0);
        chk("b_busy", busy, 1);
        run(0, 500, -1, n);
        chk("b_busy_cycles", n, 2561);
        chk("b_pass", pass, 1);
        // stuck-at-1 on word 0x5A bit 7, caught by the first r0 in E1
        stuck = 1'b1;
        go(0);
        run(0, -1, -1, n);
        chk("c_busy_cycles", n, 438);
        chk("c_done", done, 1);
        chk("c_pass", pass, 0);
        chk("c_fail_elem", fail_elem, 1);
        chk("c_fail_addr", fail_addr, 8'h5A);
        chk("c_fail_port", fail_port, 0);
        repeat (5) @(negedge clk);
        chk("c_no_issue_after_fail", bad_csb, 0);
        chk("c_done_held", done, 1);
        // port1 read of word 0xFF forced to all-ones, caught in E5
        stuck = 1'b0;
        p1f = 1'b1;
        go(0);
        chk("d_fail_addr_cleared", fail_addr, 0);
        chk("d_fail_elem_cleared", fail_elem, 0);
        run(0, -1, -1, n);
        chk("d_busy_cycles", n, 2561);
        chk("d_pass", pass, 0);
        chk("d_fail_elem", fail_elem, 5);
        chk("d_fail_addr", fail_addr, 8'hFF);
        chk("d_fail_port", fail_port, 1);
        p1f = 1'b0;
        // asynchronous reset while holding a failure result
        #3 rst_n = 1'b0;
        #1;
        chk("d_rst_done", done, 0);
        chk("d_rst_fail_elem", fail_elem, 0);
        chk("d_rst_fail_addr", fail_addr, 0);
        chk("d_rst_fail_port", fail_port, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // asynchronous reset in the middle of E3
        go(0);
        run(0, -1, 1400, n);
        chk("e_busy_before", busy, 1);
        chk("e_csb_before", csb, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("e_rst_busy", busy, 0);
        chk("e_rst_done", done, 0);
        chk("e_rst_csb", csb, 1);
        chk("e_rst_web", web, 1);
        chk("e_rst_wmask", wmask, 0);
        chk("e_rst_addr", addr, 0);
        chk("e_rst_din", din, 0);
        chk("e_rst_csb1", csb1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        go(0);
        chk("e_restart_addr", addr, 0);
        chk("e_restart_web", web, 0);
        run(0, -1, -1, n);
        chk("e_busy_cycles", n, 2561);
        chk("e_pass", pass, 1);
        // RD_LAT=2 instance, fault-free
        go(1);
        run(1, -1, -1, n);
        chk("f_busy_cycles", n, 2562);
        chk("f_done", done2, 1);
        chk("f_pass", pass2, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
